// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//
// Hazard detection and stall control for the 5-stage MIPS pipeline. It handles
// the hazards that EX-stage forwarding cannot resolve:
//   * load-use on ID operands (load result not available until after MEM),
//   * branches that compare their operands in ID while a producer is in EX
//     (one stall for an ALU producer, two for a load producer),
//   * mult/div HI/LO occupancy (a second mult/div or mfhi/mflo waits until
//     the unit is idle).
// A taken branch resolved in EX overrides all stalls: it flushes IF/ID and
// bubbles ID/EX.
//
// Parameters
//   MD_LATENCY : cycles the mult/div unit stays busy after issue (1..15)
//   SCNT_W     : width of the saturating stall-cycle counter
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   rs_d, rt_d        : source register fields of the ID instruction
//   uses_rs_d/_rt_d   : ID instruction actually reads rs / rt
//   branch_d          : ID instruction is a branch comparing operands in ID
//   md_start_d        : ID instruction is mult/multu/div/divu
//   mfhilo_d          : ID instruction is mfhi/mflo
//   rdef_final_e      : destination register of the EX instruction
//   reg_write_e       : EX instruction writes the register file
//   mem_read_e        : EX instruction is a load
//   take_branch_e     : branch resolved taken in EX this cycle
//   pc_write          : PC update enable
//   ifid_write        : IF/ID update enable
//   idex_bubble       : load a NOP into ID/EX
//   ifid_flush        : clear IF/ID to NOP
//   md_busy           : mult/div result not yet available
//   stall_cycles      : saturating count of stall cycles since reset
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned SCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs_d,
  input  logic [4:0]        rt_d,
  input  logic              uses_rs_d,
  input  logic              uses_rt_d,
  input  logic              branch_d,
  input  logic              md_start_d,
  input  logic              mfhilo_d,
  input  logic [4:0]        rdef_final_e,
  input  logic              reg_write_e,
  input  logic              mem_read_e,
  input  logic              take_branch_e,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              md_busy,
  output logic [SCNT_W-1:0] stall_cycles
);

  localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY);

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        md_cnt_q, md_cnt_d;
  logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // ---------------------------------------------------------------------------
  // Operand match against the EX destination. Both ID operands go through the
  // same comparator, so they are laid out as a small array.
  // ---------------------------------------------------------------------------
  logic [1:0][4:0] op_reg;
  logic [1:0]      op_used;
  logic [1:0]      op_match;
  logic            ex_writes_live;
  logic            match;

  assign op_reg  = {rt_d, rs_d};
  assign op_used = {uses_rt_d, uses_rs_d};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op_cmp
      assign op_match[gi] = op_used[gi] & (op_reg[gi] == rdef_final_e);
    end
  endgenerate

  // $0 is hardwired to zero, so a write to it is never a real producer.
  assign ex_writes_live = reg_write_e & (rdef_final_e != 5'd0);
  assign match          = ex_writes_live & (|op_match);

  // ---------------------------------------------------------------------------
  // Hazard terms
  // ---------------------------------------------------------------------------
  logic load_use;
  logic br_alu;
  logic br_load;
  logic md_haz;

  assign load_use = match & mem_read_e;
  assign br_alu   = branch_d & match & ~mem_read_e;
  assign br_load  = branch_d & match & mem_read_e;
  assign md_haz   = (md_cnt_q != 4'd0) & (md_start_d | mfhilo_d);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. BR_WAIT covers the second stall of a branch that
  // depends on a load; a taken branch in EX cancels it.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = RUN;
    case (state_q)
      RUN:     state_d = (br_load & ~take_branch_e) ? BR_WAIT : RUN;
      BR_WAIT: state_d = RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. The flush from a taken branch wins over any stall, since the
  // stalled ID instruction is on the wrong path anyway.
  // ---------------------------------------------------------------------------
  logic stall_raw;
  logic stall;

  always_comb begin
    stall_raw = 1'b0;
    case (state_q)
      RUN:     stall_raw = load_use | br_alu | md_haz;
      // The load is now in MEM and EX holds the bubble we injected.
      BR_WAIT: stall_raw = 1'b1;
    endcase
    stall = stall_raw & ~take_branch_e;

    pc_write    = ~stall;
    ifid_write  = ~stall;
    idex_bubble = stall | take_branch_e;
    ifid_flush  = take_branch_e;
    md_busy     = (md_cnt_q != 4'd0);

    // Hold the front end and keep the pipe full of NOPs while in reset.
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
      md_busy     = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Mult/div occupancy countdown. A new operation is only issued when it
  // actually leaves ID (not stalled, not flushed) and the unit is idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start_d & ~stall & ~take_branch_e & (md_cnt_q == 4'd0)) begin
      md_cnt_d = MD_LOAD;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt_q <= 4'd0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + SCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule
